video_pattern_source: RTL and testbench

- Stream source (transmitter) for the 12-bit RGB444 pixel stream used by our filter chain: data/sop/eop/valid out, ready in from downstream.
- Generates complete frames of synthetic test patterns: colour bars, checkerboard, gradient and solid grey.
- Drives filters and VGA sinks in simulation and in FPGA bring-up in place of the camera front end.
- Obeys downstream backpressure, so random-ready sinks can be attached directly.

---
 rtl/video_stream_pkg.sv | 25 ++
 rtl/pattern_pixel_gen.sv | 36 +++
 rtl/video_pattern_source.sv | 193 +++++++++++++++++++
 tb/tb_video_pattern_source.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_stream_pkg.sv
// Shared types and constants for the RGB444 pixel stream.
package video_stream_pkg;

    localparam int PIXEL_W = 12;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_GREY  = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_GAP
    } state_e;

    localparam pixel_t COL_WHITE = 12'hFFF;
    localparam pixel_t COL_BLACK = 12'h000;
    localparam pixel_t COL_GREY  = 12'h888;

endpackage

// File: rtl/pattern_pixel_gen.sv
// Combinational pixel generator: maps (x, y, pattern) to an RGB444 pixel.
import video_stream_pkg::*;

module pattern_pixel_gen #(
    parameter int WIDTH = 640,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  pattern_e      pattern,
    output pixel_t        pixel
);

    logic [31:0] xe;
    logic [31:0] ye;
    logic [2:0]  bar;
    logic        unused_coord_bits;

    // Select the pattern pixel; coordinates are zero-extended so narrow counters still index bits 3..7.
    always_comb begin
        xe    = 32'(x);
        ye    = 32'(y);
        bar   = 3'(xe / 32'(WIDTH / 8));
        pixel = COL_BLACK;
        case (pattern)
            PAT_BARS:  pixel = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
            PAT_CHECK: pixel = (xe[3] ^ ye[3]) ? COL_WHITE : COL_BLACK;
            PAT_GRAD:  pixel = {xe[7:4], ye[7:4], 4'h8};
            default:   pixel = COL_GREY;
        endcase
    end

    assign unused_coord_bits = ^{xe, ye};

endmodule

// File: rtl/video_pattern_source.sv
// Test-pattern stream source with backpressure, sop/eop framing and inter-frame gap.
// Optional build macro FRAME_SCROLL_EN: 8-bit frame counter scrolls patterns left one pixel per frame.
import video_stream_pkg::*;

module video_pattern_source #(
    parameter int WIDTH           = 640,
    parameter int HEIGHT          = 480,
    parameter int INTER_FRAME_GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic        ready_in,
    output logic [11:0] data_out,
    output logic        sop_out,
    output logic        eop_out,
    output logic        valid_out,
    output logic        frame_done,
    output logic        busy
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int GW = (INTER_FRAME_GAP > 1) ? $clog2(INTER_FRAME_GAP) : 1;
    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((INTER_FRAME_GAP > 0) ? INTER_FRAME_GAP - 1 : 0);

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [GW-1:0] gap_q, gap_d;
    pattern_e      pat_q, pat_d;
    pixel_t        data_q, data_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          xfer;
    logic          start_frame;
    logic [XW-1:0] pix_x;
    pixel_t        pix_d;
`ifdef FRAME_SCROLL_EN
    logic [7:0]    fcnt_q, fcnt_d;
`endif

    // Next-state logic: FSM, pixel counters, gap counter and framing flags.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        gap_d       = gap_q;
        pat_d       = pat_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        start_frame = 1'b0;
        xfer        = valid_q && ready_in;
`ifdef FRAME_SCROLL_EN
        fcnt_d      = fcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable) start_frame = 1'b1;
            end
            ST_STREAM: begin
                if (xfer) begin
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        done_d  = 1'b1;
                        x_d     = '0;
                        y_d     = '0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        valid_d = 1'b0;
`ifdef FRAME_SCROLL_EN
                        fcnt_d  = fcnt_q + 8'd1;
`endif
                        if (INTER_FRAME_GAP > 0) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end else if (enable) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sop_d = 1'b0;
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                        eop_d = (x_d == X_LAST) && (y_d == Y_LAST);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (enable) start_frame = 1'b1;
                    else        state_d     = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new frame always starts at (0,0) with the pattern sampled right now.
        if (start_frame) begin
            state_d = ST_STREAM;
            x_d     = '0;
            y_d     = '0;
            pat_d   = pattern_e'(pattern_sel);
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = (X_LAST == '0) && (Y_LAST == '0);
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Pattern x coordinate, optionally offset by the frame count.
    always_comb begin
`ifdef FRAME_SCROLL_EN
        pix_x = XW'((32'(x_d) + 32'(fcnt_d)) % WIDTH);
`else
        pix_x = x_d;
`endif
    end

    pattern_pixel_gen #(
        .WIDTH (WIDTH),
        .XW    (XW),
        .YW    (YW)
    ) u_pix (
        .x       (pix_x),
        .y       (y_d),
        .pattern (pat_d),
        .pixel   (pix_d)
    );

    // Output data is zeroed whenever no beat is presented.
    always_comb begin
        data_d = valid_d ? pix_d : '0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            gap_q   <= '0;
            pat_q   <= PAT_BARS;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef FRAME_SCROLL_EN
            fcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            gap_q   <= gap_d;
            pat_q   <= pat_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef FRAME_SCROLL_EN
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign sop_out    = sop_q;
    assign eop_out    = eop_q;
    assign valid_out  = valid_q;
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Self-checking bench for video_pattern_source (WIDTH=8, HEIGHT=4, INTER_FRAME_GAP=2).
// Honours FRAME_SCROLL_EN in its reference model when the macro is defined.
module tb_video_pattern_source;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int G     = 2;
    localparam int BEATS = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        ready_in = 1'b0;
    logic [11:0] data_out;
    logic        sop_out;
    logic        eop_out;
    logic        valid_out;
    logic        frame_done;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int m_frame  = 0;

    video_pattern_source #(
        .WIDTH           (W),
        .HEIGHT          (H),
        .INTER_FRAME_GAP (G)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .ready_in    (ready_in),
        .data_out    (data_out),
        .sop_out     (sop_out),
        .eop_out     (eop_out),
        .valid_out   (valid_out),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference pixel from the pattern definitions, using plain arithmetic.
    function automatic logic [11:0] ref_pixel(input int pat, input int x, input int y, input int frame);
        int off, sx, b, r, g, bl;
`ifdef FRAME_SCROLL_EN
        off = frame % 256;
`else
        off = 0 * frame;
`endif
        sx = (x + off) % W;
        case (pat)
            0: begin
                b  = sx / (W / 8);
                r  = ((b / 4) % 2 == 1) ? 15 : 0;
                g  = ((b / 2) % 2 == 1) ? 15 : 0;
                bl = (b % 2 == 1) ? 15 : 0;
                return 12'(r * 256 + g * 16 + bl);
            end
            1: return (((sx / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
            2: return 12'(((sx / 16) % 16) * 256 + ((y / 16) % 16) * 16 + 8);
            default: return 12'h888;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; ready_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({valid_out, sop_out, eop_out, frame_done, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {valid_out, sop_out, eop_out, frame_done, busy});
        end
        checks++;
        if (data_out !== 12'h000) begin
            failures++;
            $display("FAIL reset_data got=%h exp=000", data_out);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_dominates_enable valid got=%b exp=0", valid_out);
        end
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset valid=%b busy=%b exp=0/0", valid_out, busy);
        end
        m_frame = 0;
    endtask

    // Streams nframes from IDLE; switches pattern after switch_beat transfers of frame 0,
    // drops enable after drop_beat transfers of the last frame, then expects IDLE.
    task automatic test_stream(input int nframes, input int pct, input int pat_first,
                               input int switch_beat, input int pat_second, input int drop_beat);
        int k = 0, f = 0, phase = 0, gapc = 0, cyc = 0, sops = 0, eops = 0, cur_pat;
        logic        hold = 1'b0;
        logic [11:0] pd = '0, expd;
        logic        ps = 1'b0, pe = 1'b0;
        pattern_sel = 2'(pat_first);
        cur_pat     = pat_first;
        enable      = 1'b1;
        while (phase != 3) begin
            @(negedge clk);
            cyc++;
            if (cyc > 4000) begin
                checks++; failures++;
                $display("FAIL stream_timeout frames_done=%0d exp=%0d", f, nframes);
                phase = 3;
            end else if (phase == 0) begin
                expd = ref_pixel(cur_pat, k % W, k / W, m_frame);
                checks++;
                if (valid_out !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_valid frame=%0d beat=%0d got=%b exp=1", f, k, valid_out);
                end
                checks++;
                if (data_out !== expd) begin
                    failures++;
                    $display("FAIL stream_data frame=%0d beat=%0d pat=%0d got=%h exp=%h", f, k, cur_pat, data_out, expd);
                end
                checks++;
                if (sop_out !== (k == 0) || eop_out !== (k == BEATS - 1)) begin
                    failures++;
                    $display("FAIL stream_sop_eop beat=%0d got=%b%b exp=%b%b", k, sop_out, eop_out, k == 0, k == BEATS - 1);
                end
                checks++;
                if (busy !== 1'b1 || frame_done !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_busy_done beat=%0d got=%b%b exp=10", k, busy, frame_done);
                end
                if (hold) begin
                    checks++;
                    if (data_out !== pd || sop_out !== ps || eop_out !== pe) begin
                        failures++;
                        $display("FAIL stall_hold got=%h/%b/%b exp=%h/%b/%b", data_out, sop_out, eop_out, pd, ps, pe);
                    end
                end
                pd = data_out; ps = sop_out; pe = eop_out;
                ready_in = ($urandom_range(0, 99) < pct);
                hold = valid_out && !ready_in;
                if (valid_out && ready_in) begin
                    if (sop_out) sops++;
                    if (eop_out) eops++;
                    k++;
                    if (f == 0 && k == switch_beat) pattern_sel = 2'(pat_second);
                    if (f == nframes - 1 && k == drop_beat) enable = 1'b0;
                    if (k == BEATS) begin
                        k = 0; f++; m_frame++; phase = 1; gapc = 0; hold = 1'b0;
                    end
                end
            end else if (phase == 1) begin
                gapc++;
                checks++;
                if (valid_out !== 1'b0 || busy !== 1'b1 || frame_done !== (gapc == 1)) begin
                    failures++;
                    $display("FAIL gap_cycle%0d valid/busy/done got=%b%b%b exp=01%b", gapc, valid_out, busy, frame_done, gapc == 1);
                end
                if (gapc == G) begin
                    if (f == nframes) phase = 2;
                    else begin
                        phase = 0;
                        cur_pat = int'(pattern_sel);
                    end
                end
            end else begin
                checks++;
                if (valid_out !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                    failures++;
                    $display("FAIL end_idle valid/busy/done got=%b%b%b exp=000", valid_out, busy, frame_done);
                end
                checks++;
                if (sops != nframes || eops != nframes) begin
                    failures++;
                    $display("FAIL sop_eop_count got=%0d/%0d exp=%0d/%0d", sops, eops, nframes, nframes);
                end
                phase = 3;
            end
        end
    endtask

    task automatic test_midframe_reset();
        int p1, p2, eops = 0;
        logic [11:0] expd;
        p1 = int'($urandom_range(0, 3));
        p2 = int'($urandom_range(0, 3));
        pattern_sel = 2'(p1); enable = 1'b1; ready_in = 1'b1;
        repeat (12) @(negedge clk);
        expd = ref_pixel(p1, 11 % W, 11 / W, m_frame);
        checks++;
        if (valid_out !== 1'b1 || data_out !== expd) begin
            failures++;
            $display("FAIL midframe_beat12 valid=%b data=%h exp=1/%h", valid_out, data_out, expd);
        end
        reset = 1'b0;
        @(negedge clk);
        m_frame = 0;
        checks++;
        if ({valid_out, sop_out, eop_out, busy, frame_done} !== 5'b0 || data_out !== 12'h000) begin
            failures++;
            $display("FAIL midframe_reset_outputs got=%b data=%h exp=00000/000", {valid_out, sop_out, eop_out, busy, frame_done}, data_out);
        end
        reset = 1'b1; pattern_sel = 2'(p2);
        @(negedge clk);
        expd = ref_pixel(p2, 0, 0, 0);
        checks++;
        if (valid_out !== 1'b1 || sop_out !== 1'b1 || eop_out !== 1'b0 || data_out !== expd) begin
            failures++;
            $display("FAIL restart_sop valid/sop/eop=%b%b%b data=%h exp=110/%h", valid_out, sop_out, eop_out, data_out, expd);
        end
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid_out && eop_out) eops++;
            if (!busy) break;
        end
        checks++;
        if (busy !== 1'b0 || eops != 1) begin
            failures++;
            $display("FAIL restart_frame_complete busy=%b eops=%0d exp=0/1", busy, eops);
        end
        m_frame = 1;
    endtask

    initial begin
        test_reset();
        test_stream(2, 100, 0, 10, 1, 32);
        test_stream(3, 75, 1, -1, 1, 5);
        test_stream(1, 100, 0, -1, 0, 10);
        test_stream(2, 100, 0, -1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            test_stream(int'($urandom_range(1, 2)), int'($urandom_range(30, 100)), int'($urandom_range(0, 3)),
                        int'($urandom_range(1, 31)), int'($urandom_range(0, 3)), int'($urandom_range(1, 32)));
        end
        test_midframe_reset();
        test_stream(1, 60, 2, -1, 2, 16);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
